// File: rtl/wb_ic_pkg.sv
// Shared types for the Wishbone interconnect: FSM state encoding, fault type codes
// and the width helper used to size the slave timeout counter.
package wb_ic_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StDecodeErr = 2'd1,
    StActive    = 2'd2,
    StTimeout   = 2'd3
  } ic_state_e;

  typedef enum logic {
    FaultDecode  = 1'b0,
    FaultTimeout = 1'b1
  } fault_type_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/wb_interconnect_if.sv
// Wishbone master-side and slave-side bundle for wb_interconnect.
// Modports: master (bus master), slave (slave array), ic (the interconnect itself).
interface wb_interconnect_if #(
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
);

  logic [ADDR_W-1:0]          m_addr_i;
  logic [DATA_W-1:0]          m_dat_i;
  logic [DATA_W-1:0]          m_dat_o;
  logic                       m_we_i;
  logic [DATA_W/8-1:0]        m_sel_i;
  logic                       m_cyc_i;
  logic                       m_stb_i;
  logic                       m_lock_i;
  logic                       m_ack_o;
  logic                       m_err_o;
  logic                       m_rty_o;

  logic [ADDR_W-1:0]          s_addr_o;
  logic [DATA_W-1:0]          s_dat_o;
  logic                       s_we_o;
  logic [DATA_W/8-1:0]        s_sel_o;
  logic [N_SLAVES-1:0]        s_cyc_o;
  logic [N_SLAVES-1:0]        s_stb_o;
  logic [N_SLAVES*DATA_W-1:0] s_dat_i;
  logic [N_SLAVES-1:0]        s_ack_i;
  logic [N_SLAVES-1:0]        s_err_i;
  logic [N_SLAVES-1:0]        s_rty_i;

  modport master (
    output m_addr_i, m_dat_i, m_we_i, m_sel_i, m_cyc_i, m_stb_i, m_lock_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o
  );

  modport slave (
    input  s_addr_o, s_dat_o, s_we_o, s_sel_o, s_cyc_o, s_stb_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

  modport ic (
    input  m_addr_i, m_dat_i, m_we_i, m_sel_i, m_cyc_i, m_stb_i, m_lock_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_addr_o, s_dat_o, s_we_o, s_sel_o, s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

endinterface

// File: rtl/wb_ic_decoder.sv
// Combinational address map check: slave index from the region field, hit only when the
// index is populated and every address bit above the field is zero.
module wb_ic_decoder #(
  parameter int unsigned N_SLAVES    = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned REGION_BITS = 8,
  parameter int unsigned IDX_W       = 2
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o
);

  localparam int unsigned NumIdx   = 2 ** IDX_W;
  localparam int unsigned UpperLsb = REGION_BITS + IDX_W;

  logic [NumIdx-1:0] idx_valid;

  always_comb begin
    idx_valid = '0;
    for (int unsigned k = 0; k < NumIdx; k++) begin
      idx_valid[k] = (k < N_SLAVES);
    end
  end

  assign idx_o = addr_i[REGION_BITS +: IDX_W];
  assign hit_o = idx_valid[idx_o] && ((addr_i >> UpperLsb) == '0);

endmodule

// File: rtl/wb_interconnect.sv
// Single-master, N-slave Wishbone classic interconnect with decode/timeout error answers
// and a saturating fault counter. Define WB_IC_FAULT_CAPTURE_EN to add fault address/type capture.
module wb_interconnect
  import wb_ic_pkg::*;
#(
  parameter int unsigned N_SLAVES       = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned REGION_BITS    = 8,
  parameter int unsigned IDX_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              ext_rst_i,
  wb_interconnect_if.ic     bus,
  output logic [7:0]        fault_count_o,
`ifdef WB_IC_FAULT_CAPTURE_EN
  output logic [ADDR_W-1:0] fault_addr_o,
  output logic              fault_type_o,
`endif
  output logic              busy_o
);

  localparam int unsigned    TmoW    = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  ic_state_e        state_q;
  logic [IDX_W-1:0] idx_q;
  logic             cyc_q;
  logic             stb_q;
  logic [TmoW-1:0]  tmo_cnt_q;
  logic [7:0]       fault_cnt_q;

  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;

  wb_ic_decoder #(
    .N_SLAVES    (N_SLAVES),
    .ADDR_W      (ADDR_W),
    .REGION_BITS (REGION_BITS),
    .IDX_W       (IDX_W)
  ) u_decoder (
    .addr_i (bus.m_addr_i),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  logic              sel_ack;
  logic              sel_err;
  logic              sel_rty;
  logic [DATA_W-1:0] sel_dat;

  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_rty = 1'b0;
    sel_dat = '0;
    bus.s_cyc_o = '0;
    bus.s_stb_o = '0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      bus.s_cyc_o[k] = cyc_q && (idx_q == IDX_W'(k));
      bus.s_stb_o[k] = stb_q && (idx_q == IDX_W'(k));
      if (idx_q == IDX_W'(k)) begin
        sel_ack = bus.s_ack_i[k];
        sel_err = bus.s_err_i[k];
        sel_rty = bus.s_rty_i[k];
        sel_dat = bus.s_dat_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // A response only counts while the selected slave is strobed and the master still owns the bus.
  logic resp_valid;
  logic any_resp;
  logic req;
  logic dec_miss_enter;
  logic tmo_enter;
  logic [7:0] fault_cnt_inc;

  assign req            = bus.m_cyc_i && bus.m_stb_i;
  assign resp_valid     = (state_q == StActive) && stb_q && bus.m_cyc_i;
  assign any_resp       = resp_valid && (sel_ack || sel_err || sel_rty);
  assign dec_miss_enter = (state_q == StIdle) && req && !dec_hit;
  assign tmo_enter      = (state_q == StActive) && bus.m_cyc_i && !any_resp &&
                          (tmo_cnt_q == TmoLast);
  assign fault_cnt_inc  = (fault_cnt_q == 8'hFF) ? fault_cnt_q : fault_cnt_q + 8'd1;

  assign bus.s_addr_o = bus.m_addr_i;
  assign bus.s_dat_o  = bus.m_dat_i;
  assign bus.s_we_o   = bus.m_we_i;
  assign bus.s_sel_o  = bus.m_sel_i;

  // Err beats ack, ack beats rty.
  assign bus.m_err_o = (state_q == StDecodeErr) || (state_q == StTimeout) ||
                       (resp_valid && sel_err);
  assign bus.m_ack_o = resp_valid && sel_ack && !sel_err;
  assign bus.m_rty_o = resp_valid && sel_rty && !sel_err && !sel_ack;
  assign bus.m_dat_o = (state_q == StActive) ? sel_dat : '0;

  assign fault_count_o = fault_cnt_q;
  assign busy_o        = (state_q != StIdle);

  always_ff @(posedge clk_i or negedge ext_rst_i) begin
    if (!ext_rst_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      tmo_cnt_q   <= '0;
      fault_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            idx_q     <= dec_idx;
            tmo_cnt_q <= '0;
            if (dec_hit) begin
              state_q <= StActive;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
            end else begin
              state_q     <= StDecodeErr;
              fault_cnt_q <= fault_cnt_inc;
            end
          end
        end
        StActive: begin
          if (!bus.m_cyc_i) begin
            state_q <= StIdle;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
          end else if (any_resp) begin
            tmo_cnt_q <= '0;
            stb_q     <= 1'b0;
            if (!bus.m_lock_i) begin
              state_q <= StIdle;
              cyc_q   <= 1'b0;
            end
          end else if (tmo_enter) begin
            state_q     <= StTimeout;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            fault_cnt_q <= fault_cnt_inc;
          end else if (!stb_q && bus.m_stb_i) begin
            // Locked follow-on access reuses the held index.
            stb_q     <= 1'b1;
            tmo_cnt_q <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
        end
        StDecodeErr, StTimeout: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef WB_IC_FAULT_CAPTURE_EN
  always_ff @(posedge clk_i or negedge ext_rst_i) begin
    if (!ext_rst_i) begin
      fault_addr_o <= '0;
      fault_type_o <= FaultDecode;
    end else if (dec_miss_enter) begin
      fault_addr_o <= bus.m_addr_i;
      fault_type_o <= FaultDecode;
    end else if (tmo_enter) begin
      fault_addr_o <= bus.m_addr_i;
      fault_type_o <= FaultTimeout;
    end
  end
`else
  logic unused_dec_miss;
  assign unused_dec_miss = dec_miss_enter;
`endif

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed bench for wb_interconnect: decode, zero-latency response, timeout, lock,
// abort, async reset and fault counter saturation.
module tb_wb_interconnect;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] fault_count;
  logic       busy;
`ifdef WB_IC_FAULT_CAPTURE_EN
  logic [AW-1:0] fault_addr;
  logic          fault_type;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int stb_cycles;

  always #5 clk = ~clk;

  wb_interconnect_if #(.N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

  wb_interconnect #(
    .N_SLAVES       (NS),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .REGION_BITS    (8),
    .IDX_W          (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i         (clk),
    .ext_rst_i     (rst_n),
    .bus           (bus),
    .fault_count_o (fault_count),
`ifdef WB_IC_FAULT_CAPTURE_EN
    .fault_addr_o  (fault_addr),
    .fault_type_o  (fault_type),
`endif
    .busy_o        (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [AW-1:0] addr, input logic we, input logic lock);
    bus.m_addr_i = addr;
    bus.m_we_i   = we;
    bus.m_lock_i = lock;
    bus.m_cyc_i  = 1'b1;
    bus.m_stb_i  = 1'b1;
  endtask

  task automatic release_bus();
    bus.m_cyc_i  = 1'b0;
    bus.m_stb_i  = 1'b0;
    bus.m_lock_i = 1'b0;
    bus.s_ack_i  = '0;
    bus.s_err_i  = '0;
    bus.s_rty_i  = '0;
  endtask

  initial begin
    bus.m_addr_i = '0;
    bus.m_dat_i  = 32'h1234_5678;
    bus.m_we_i   = 1'b0;
    bus.m_sel_i  = 4'hF;
    bus.s_dat_i  = '0;
    release_bus();

    // Reset state
    #1;
    check("rst_s_cyc", bus.s_cyc_o, 4'b0000);
    check("rst_s_stb", bus.s_stb_o, 4'b0000);
    check("rst_ack", bus.m_ack_o, 1'b0);
    check("rst_err", bus.m_err_o, 1'b0);
    check("rst_rty", bus.m_rty_o, 1'b0);
    check("rst_dat", bus.m_dat_o, 32'h0);
    check("rst_fault", fault_count, 8'd0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Read slave 1, ack in cycle 3
    @(negedge clk);
    start(32'h0000_0104, 1'b0, 1'b0);
    #1;
    check("rd_addr_copy", bus.s_addr_o, 32'h0000_0104);
    check("rd_sel_copy", bus.s_sel_o, 4'hF);
    check("rd_stb_early", bus.s_stb_o, 4'b0000);
    @(negedge clk);
    check("rd_stb", bus.s_stb_o, 4'b0010);
    check("rd_cyc", bus.s_cyc_o, 4'b0010);
    check("rd_no_ack", bus.m_ack_o, 1'b0);
    @(negedge clk);
    bus.s_dat_i[32 +: 32] = 32'hDEAD_BEEF;
    bus.s_ack_i = 4'b0010;
    #1;
    check("rd_ack", bus.m_ack_o, 1'b1);
    check("rd_dat", bus.m_dat_o, 32'hDEAD_BEEF);
    check("rd_err", bus.m_err_o, 1'b0);
    @(negedge clk);
    release_bus();
    #1;
    check("rd_idle", busy, 1'b0);
    check("rd_idle_stb", bus.s_stb_o, 4'b0000);
    check("rd_idle_dat", bus.m_dat_o, 32'h0);

    // Decode miss
    @(negedge clk);
    start(32'h0000_0400, 1'b0, 1'b0);
    @(negedge clk);
    check("miss_err", bus.m_err_o, 1'b1);
    check("miss_stb", bus.s_stb_o, 4'b0000);
    check("miss_cyc", bus.s_cyc_o, 4'b0000);
    check("miss_fault", fault_count, 8'd1);
`ifdef WB_IC_FAULT_CAPTURE_EN
    check("miss_faddr", fault_addr, 32'h0000_0400);
    check("miss_ftype", fault_type, 1'b0);
`endif
    release_bus();
    @(negedge clk);
    check("miss_err_end", bus.m_err_o, 1'b0);
    check("miss_idle", busy, 1'b0);

    // Slave 2 never answers
    start(32'h0000_0200, 1'b0, 1'b0);
    stb_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.s_stb_o == 4'b0100) stb_cycles++;
      else break;
    end
    check("tmo_stb_len", stb_cycles, 8);
    check("tmo_err", bus.m_err_o, 1'b1);
    check("tmo_cyc", bus.s_cyc_o, 4'b0000);
    check("tmo_fault", fault_count, 8'd2);
    release_bus();
    @(negedge clk);
    check("tmo_err_end", bus.m_err_o, 1'b0);
    check("tmo_idle", busy, 1'b0);

    // Slave 0: unselected ack ignored, then ack+err together
    start(32'h0000_0000, 1'b0, 1'b0);
    @(negedge clk);
    check("ae_stb", bus.s_stb_o, 4'b0001);
    bus.s_ack_i = 4'b1000;
    #1;
    check("ae_foreign_ack", bus.m_ack_o, 1'b0);
    @(negedge clk);
    check("ae_still_busy", busy, 1'b1);
    bus.s_ack_i = 4'b1001;
    bus.s_err_i = 4'b0001;
    #1;
    check("ae_err", bus.m_err_o, 1'b1);
    check("ae_ack", bus.m_ack_o, 1'b0);
    @(negedge clk);
    release_bus();
    #1;
    check("ae_idle", busy, 1'b0);
    check("ae_fault", fault_count, 8'd2);

    // Locked back-to-back writes to slave 0
    @(negedge clk);
    start(32'h0000_0010, 1'b1, 1'b1);
    @(negedge clk);
    check("lk_stb1", bus.s_stb_o, 4'b0001);
    check("lk_we", bus.s_we_o, 1'b1);
    bus.s_ack_i = 4'b0001;
    #1;
    check("lk_ack1", bus.m_ack_o, 1'b1);
    @(negedge clk);
    bus.s_ack_i = 4'b0000;
    bus.m_addr_i = 32'h0000_0104;
    #1;
    check("lk_gap_cyc", bus.s_cyc_o, 4'b0001);
    check("lk_gap_stb", bus.s_stb_o, 4'b0000);
    @(negedge clk);
    check("lk_stb2", bus.s_stb_o, 4'b0001);
    check("lk_cyc2", bus.s_cyc_o, 4'b0001);
    bus.s_ack_i = 4'b0001;
    bus.m_lock_i = 1'b0;
    #1;
    check("lk_ack2", bus.m_ack_o, 1'b1);
    @(negedge clk);
    check("lk_idle_cyc", bus.s_cyc_o, 4'b0000);
    check("lk_idle", busy, 1'b0);
    release_bus();

    // Master abort mid-ACTIVE
    @(negedge clk);
    start(32'h0000_0000, 1'b0, 1'b0);
    @(negedge clk);
    check("ab_stb", bus.s_stb_o, 4'b0001);
    bus.m_cyc_i = 1'b0;
    bus.m_stb_i = 1'b0;
    bus.s_ack_i = 4'b0001;
    #1;
    check("ab_no_ack", bus.m_ack_o, 1'b0);
    @(negedge clk);
    check("ab_idle", busy, 1'b0);
    check("ab_cyc", bus.s_cyc_o, 4'b0000);
    release_bus();

    // Async reset during ACTIVE
    @(negedge clk);
    start(32'h0000_0100, 1'b0, 1'b0);
    @(negedge clk);
    check("ar_stb", bus.s_stb_o, 4'b0010);
    bus.s_dat_i[32 +: 32] = 32'hCAFE_F00D;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_stb_cleared", bus.s_stb_o, 4'b0000);
    check("ar_cyc_cleared", bus.s_cyc_o, 4'b0000);
    check("ar_busy", busy, 1'b0);
    check("ar_dat", bus.m_dat_o, 32'h0);
    check("ar_fault", fault_count, 8'd0);
    @(negedge clk);
    release_bus();
    rst_n = 1'b1;

    // Fault counter saturation
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      start(32'h0001_0000, 1'b0, 1'b0);
      @(negedge clk);
      release_bus();
      if (i == 254) check("sat_254", fault_count, 8'd254);
      if (i == 255) check("sat_255", fault_count, 8'd255);
    end
    @(negedge clk);
    check("sat_300", fault_count, 8'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
